regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Command sequencer that drives the 8×16 register file from the initiator side. Accepts one 16-bit instruction per valid/ready handshake, decodes it, and issues the register file's `readnum`, `writenum`, `write` and `data_in` in a fixed multi-cycle sequence. It samples `data_out` from the register file and reports completion, and any read result, back to the issuer. It sits between the instruction source (test harness now, fetch unit later) and the register file, inside the RISC machine datapath.

## Interface
- `IMM_W`, default 8: immediate field width; sign-extended to 16.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `cmd_valid` input, 1 bit: instruction on `cmd` is valid.
- `cmd_ready` output, 1 bit: controller can accept an instruction; high only in IDLE.
- `cmd` input, 16 bits: instruction word.
- `readnum` output, 3 bits: register file read select.
- `data_out` input, 16 bits: register file read data; combinational from `readnum`.
- `writenum` output, 3 bits: register file write select.
- `write` output, 1 bit: register file write enable; the write occurs on the edge that ends the cycle.
- `data_in` output, 16 bits: register file write data.
- `done` output, 1 bit: one-cycle pulse when an instruction completes.
- `err` output, 1 bit: qualifies `done`; the instruction was illegal and had no effect.
- `result` output, 16 bits: value read by RDR; holds until the next RDR completes.

## Operation
- Fields:
  - `op` = cmd[15:13]
  - `sub` = cmd[12:11]
  - `Rn` = cmd[10:8]
  - `Rd` = cmd[7:5]
  - `Rm` = cmd[2:0]
  - `imm` = cmd[7:0]
- Instructions:
  - MOVI (op 110, sub 10): Rn ← sext(imm).
  - MOV (op 110, sub 00): Rd ← Rm.
  - ADD (op 101, sub 00): Rd ← Rn + Rm, modulo 2^16, no carry or flags.
  - RDR (op 111, sub 00): result ← Rn, no write.
  - Any other op/sub: illegal. No register access; `done` and `err` both pulse.
- Handshake: the transfer occurs on a rising edge with `cmd_valid` and `cmd_ready` both high. `cmd` is latched into an internal instruction register. `cmd` is not looked at after acceptance.
- States:
  - IDLE: `cmd_ready`=1. On transfer, go to RD_A for ADD or RDR, RD_B for MOV, WB for MOVI, DONE for illegal.
  - RD_A: `readnum`=Rn. `data_out` is captured into `reg_a` at the edge. Then go to RD_B for ADD; for RDR, `reg_a` is loaded into `result` and go to DONE.
  - RD_B: `readnum`=Rm. `data_out` is captured into `reg_b`. Then go to WB.
  - WB: `write`=1. `writenum`=Rn for MOVI, Rd otherwise. `data_in`=sext(imm) for MOVI, `reg_b` for MOV, `reg_a`+`reg_b` for ADD. Then go to DONE.
  - DONE: `done`=1, and `err`=1 if illegal. Then go to IDLE.
- `write` is asserted only in WB, and for exactly one cycle per MOVI, MOV or ADD.
- All reads for an instruction complete before its write, so ADD R3,R3,R3 doubles R3.
- Back-to-back: the next instruction reads after the previous write edge, so it sees the new value. No forwarding is needed.

## Timing
- Reset values:
  - State is IDLE, so `cmd_ready`=1.
  - `write`=0, `done`=0, `err`=0.
  - `readnum`=0, `writenum`=0, `data_in`=0, `result`=0, `reg_a`=`reg_b`=0.
- Reset mid-instruction: abort immediately and return to IDLE. No `write` is asserted after `reset_n` falls, and no `done` is issued for the aborted instruction. Register contents already written are kept.
- Latency, counted from the accept edge to the cycle in which `done` is high:
  - illegal: 1
  - MOVI: 2
  - RDR: 2
  - MOV: 3
  - ADD: 4
- Throughput: one instruction per (latency + 1) cycles. `cmd_ready` returns high in the cycle after DONE.
- `readnum` is don't-care outside RD_A and RD_B, but must be driven as a registered or decoded value with no X.
- `cmd_valid` held high with `cmd_ready` low is legal. The instruction is accepted on the first edge in IDLE.

## Structure
- Shared constants package `regfile_ctrl_pkg`:
  - state encodings (IDLE, RD_A, RD_B, WB, DONE)
  - opcode and sub-op constants
  - field bit positions
  - `REG_W` = 16, `SEL_W` = 3
- Sub-module `instr_decode` (combinational): takes the instruction register and outputs an instruction class (MOVI, MOV, ADD, RDR, ILLEGAL), the three register selects, and sign-extended `imm`.
- The top level holds the FSM, the instruction register, `reg_a`, `reg_b`, `result` and the adder.

## Test plan
- Reset, then MOVI R2,#0x85 -> `write`=1 for one cycle with `writenum`=2, `data_in`=0xFF85; `done` 2 cycles after accept; R2 = 0xFF85.
- MOVI R1,#5; MOVI R4,#0x7F; ADD R7,R1,R4 -> ADD `done` 4 cycles after accept; `data_in`=0x0084; R7 = 0x0084.
- MOVI R0,#-1; ADD R0,R0,R0 -> R0 = 0xFFFE (wrap, reads precede write); then RDR R0 -> `result`=0xFFFE 2 cycles after accept.
- MOV R5,R2 after R2=0xFF85 -> `readnum`=2 in RD_B, then `writenum`=5; R5 = 0xFF85; `cmd_ready` low for 3 cycles.
- Illegal cmd 0x0000 with `cmd_valid` held high -> `done`=`err`=1 one cycle after accept; no `write`; next instruction accepted 2 edges after the first.
- Assert `reset_n`=0 during the RD_B cycle of ADD -> `write` never asserts, `done` stays 0, all outputs return to reset values, and the destination register is unchanged.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file command sequencer: widths,
// instruction field positions, opcode/sub-op values, state and class enums.
package regfile_ctrl_pkg;

    localparam int REG_W = 16;
    localparam int SEL_W = 3;

    // Instruction field bit positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int SUB_HI = 12;
    localparam int SUB_LO = 11;
    localparam int RN_HI  = 10;
    localparam int RN_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int RM_HI  = 2;
    localparam int RM_LO  = 0;

    // Opcodes
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;
    localparam logic [2:0] OP_RDR = 3'b111;

    // Sub-ops
    localparam logic [1:0] SUB_MOVI = 2'b10;
    localparam logic [1:0] SUB_MOV  = 2'b00;
    localparam logic [1:0] SUB_ADD  = 2'b00;
    localparam logic [1:0] SUB_RDR  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_WB,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        IC_MOVI,
        IC_MOV,
        IC_ADD,
        IC_RDR,
        IC_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/regfile_ctrl_decode.sv
// Combinational instruction decoder: classifies the instruction word and
// extracts register selects plus the sign-extended immediate.
module instr_decode
    import regfile_ctrl_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic [REG_W-1:0] instr,
    output instr_class_e     iclass,
    output logic [SEL_W-1:0] rn,
    output logic [SEL_W-1:0] rd,
    output logic [SEL_W-1:0] rm,
    output logic [REG_W-1:0] imm_sext
);

    logic [2:0] op;
    logic [1:0] sub;

    assign op       = instr[OP_HI:OP_LO];
    assign sub      = instr[SUB_HI:SUB_LO];
    assign rn       = instr[RN_HI:RN_LO];
    assign rd       = instr[RD_HI:RD_LO];
    assign rm       = instr[RM_HI:RM_LO];
    assign imm_sext = REG_W'($signed(instr[IMM_W-1:0]));

    // Map op/sub pairs to an instruction class; everything else is illegal
    always_comb begin
        iclass = IC_ILLEGAL;
        case ({op, sub})
            {OP_MOV, SUB_MOVI}: iclass = IC_MOVI;
            {OP_MOV, SUB_MOV }: iclass = IC_MOV;
            {OP_ALU, SUB_ADD }: iclass = IC_ADD;
            {OP_RDR, SUB_RDR }: iclass = IC_RDR;
            default:            iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Command sequencer driving an 8x16 register file: accepts one instruction
// per handshake and steps through read / write-back / done states.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [REG_W-1:0] cmd,
    output logic [SEL_W-1:0] readnum,
    input  logic [REG_W-1:0] data_out,
    output logic [SEL_W-1:0] writenum,
    output logic             write,
    output logic [REG_W-1:0] data_in,
    output logic             done,
    output logic             err,
    output logic [REG_W-1:0] result
);

    state_e           state_reg;
    state_e           state_next;
    logic [REG_W-1:0] ir_reg;
    logic [REG_W-1:0] reg_a_reg;
    logic [REG_W-1:0] reg_b_reg;
    logic [REG_W-1:0] result_reg;

    logic [REG_W-1:0] dec_instr;
    instr_class_e     dec_class;
    logic [SEL_W-1:0] dec_rn;
    logic [SEL_W-1:0] dec_rd;
    logic [SEL_W-1:0] dec_rm;
    logic [REG_W-1:0] dec_imm;
    logic [REG_W-1:0] sum;
    logic             accept;

    // In IDLE the incoming word is decoded to pick the first state; once
    // accepted, every later state works from the latched instruction.
    assign dec_instr = (state_reg == ST_IDLE) ? cmd : ir_reg;
    assign accept    = cmd_valid && (state_reg == ST_IDLE);
    assign sum       = reg_a_reg + reg_b_reg;
    assign result    = result_reg;

    instr_decode #(
        .IMM_W (IMM_W)
    ) u_decode (
        .instr    (dec_instr),
        .iclass   (dec_class),
        .rn       (dec_rn),
        .rd       (dec_rd),
        .rm       (dec_rm),
        .imm_sext (dec_imm)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction register, loaded only on the accepting edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg <= '0;
        end else if (accept) begin
            ir_reg <= cmd;
        end
    end

    // Operand capture from the register file, and RDR result update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_a_reg  <= '0;
            reg_b_reg  <= '0;
            result_reg <= '0;
        end else begin
            if (state_reg == ST_RD_A) begin
                reg_a_reg <= data_out;
                // Take the same value going into reg_a so result is
                // visible in the DONE cycle that immediately follows.
                if (dec_class == IC_RDR) begin
                    result_reg <= data_out;
                end
            end
            if (state_reg == ST_RD_B) begin
                reg_b_reg <= data_out;
            end
        end
    end

    // Next-state and per-state register-file / completion outputs
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        readnum    = '0;
        writenum   = '0;
        write      = 1'b0;
        data_in    = '0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (dec_class)
                        IC_ADD, IC_RDR: state_next = ST_RD_A;
                        IC_MOV:         state_next = ST_RD_B;
                        IC_MOVI:        state_next = ST_WB;
                        default:        state_next = ST_DONE;
                    endcase
                end
            end
            ST_RD_A: begin
                readnum    = dec_rn;
                state_next = (dec_class == IC_ADD) ? ST_RD_B : ST_DONE;
            end
            ST_RD_B: begin
                readnum    = dec_rm;
                state_next = ST_WB;
            end
            ST_WB: begin
                write    = 1'b1;
                writenum = (dec_class == IC_MOVI) ? dec_rn : dec_rd;
                case (dec_class)
                    IC_MOVI: data_in = dec_imm;
                    IC_MOV:  data_in = reg_b_reg;
                    default: data_in = sum;
                endcase
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                err        = (dec_class == IC_ILLEGAL);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a behavioural
// 8x16 register file attached to its initiator-side ports.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_ready;
    logic [2:0]  readnum;
    logic [15:0] data_out;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] data_in;
    logic        done;
    logic        err;
    logic [15:0] result;

    logic [15:0] rf [8];
    logic        rf_clear = 1'b1;
    logic [2:0]  rn_seq [1:4];
    logic [15:0] last_result;
    int          checks = 0;
    int          failures = 0;
    int          wr_seen;
    int          done_seen;

    always #5 clk = ~clk;

    regfile_ctrl #(
        .IMM_W (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .readnum   (readnum),
        .data_out  (data_out),
        .writenum  (writenum),
        .write     (write),
        .data_in   (data_in),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    // Register file: combinational read, write on the rising edge
    assign data_out = rf[readnum];

    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
        end else if (write) begin
            rf[writenum] <= data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from an IDLE negedge and watch it to completion
    task automatic exec(input logic [15:0] c, input string name, input int lat,
                        input int exp_wr, input logic [2:0] exp_wn, input logic [15:0] exp_din);
        int          done_cyc;
        int          wr_cnt;
        int          ready_low;
        logic [2:0]  wn;
        logic [15:0] din;
        logic        err_d;
        logic [15:0] res_d;
        done_cyc = 0; wr_cnt = 0; ready_low = 0;
        wn = 3'd0; din = 16'h0; err_d = 1'b0; res_d = 16'h0;
        check({name, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd = c;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd = 16'hFFFF;
            end
            if (k <= 4) rn_seq[k] = readnum;
            if (!cmd_ready) ready_low++;
            if (done && done_cyc == 0) begin
                done_cyc = k;
                err_d = err;
                res_d = result;
            end
            if (write) begin
                wr_cnt++;
                wn = writenum;
                din = data_in;
            end
        end
        check({name, "_latency"}, 32'(done_cyc), 32'(lat));
        check({name, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({name, "_err"}, 32'(err_d), 32'd0);
        check({name, "_ready_low"}, 32'(ready_low), 32'(lat));
        if (exp_wr != 0) begin
            check({name, "_writenum"}, 32'(wn), 32'(exp_wn));
            check({name, "_data_in"}, 32'(din), 32'(exp_din));
        end
        last_result = res_d;
        $display("txn %-10s cmd=%h done@%0d writes=%0d writenum=%0d data_in=%h result=%h",
                 name, c, done_cyc, wr_cnt, wn, din, res_d);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_write", 32'(write), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_readnum", 32'(readnum), 32'd0);
        check("rst_writenum", 32'(writenum), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        $display("txn reset      ready=%0b write=%0b done=%0b result=%h", cmd_ready, write, done, result);
        reset_n = 1'b1;
        rf_clear = 1'b0;
        @(negedge clk);

        // MOVI R2,#0x85 sign-extends to 0xFF85
        exec(16'hD285, "movi_r2", 2, 1, 3'd2, 16'hFF85);
        check("rf_r2", 32'(rf[2]), 32'h0000FF85);

        // MOVI R1,#5; MOVI R4,#0x7F; ADD R7,R1,R4
        exec(16'hD105, "movi_r1", 2, 1, 3'd1, 16'h0005);
        exec(16'hD47F, "movi_r4", 2, 1, 3'd4, 16'h007F);
        exec(16'hA1E4, "add_r7", 4, 1, 3'd7, 16'h0084);
        check("add_r7_rd_a_sel", 32'(rn_seq[1]), 32'd1);
        check("add_r7_rd_b_sel", 32'(rn_seq[2]), 32'd4);
        check("rf_r7", 32'(rf[7]), 32'h00000084);

        // MOVI R0,#-1; ADD R0,R0,R0 wraps; RDR R0
        exec(16'hD0FF, "movi_r0", 2, 1, 3'd0, 16'hFFFF);
        exec(16'hA000, "add_r0", 4, 1, 3'd0, 16'hFFFE);
        check("rf_r0", 32'(rf[0]), 32'h0000FFFE);
        exec(16'hE000, "rdr_r0", 2, 0, 3'd0, 16'h0000);
        check("rdr_r0_result", 32'(last_result), 32'h0000FFFE);
        check("rdr_r0_hold", 32'(result), 32'h0000FFFE);

        // MOV R5,R2
        exec(16'hC0A2, "mov_r5", 3, 1, 3'd5, 16'hFF85);
        check("mov_r5_rd_b_sel", 32'(rn_seq[1]), 32'd2);
        check("rf_r5", 32'(rf[5]), 32'h0000FF85);
        check("mov_result_hold", 32'(result), 32'h0000FFFE);

        // Illegal 0x0000 with cmd_valid held, then MOVI R3,#0x12 back to back
        check("ill_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd = 16'h0000;
        @(negedge clk);
        check("ill_done", 32'(done), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_write", 32'(write), 32'd0);
        check("ill_ready_low", 32'(cmd_ready), 32'd0);
        cmd = 16'hD312;
        @(negedge clk);
        check("ill_next_ready", 32'(cmd_ready), 32'd1);
        check("ill_next_done", 32'(done), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ill_next_write", 32'(write), 32'd1);
        check("ill_next_writenum", 32'(writenum), 32'd3);
        check("ill_next_data_in", 32'(data_in), 32'h00000012);
        @(negedge clk);
        check("ill_next_done2", 32'(done), 32'd1);
        check("ill_next_err2", 32'(err), 32'd0);
        @(negedge clk);
        check("rf_r3", 32'(rf[3]), 32'h00000012);
        $display("txn illegal    cmd=0000 then movi_r3 accepted on second edge, r3=%h", rf[3]);

        // ADD R7,R2,R2 aborted by reset during RD_B
        cmd_valid = 1'b1;
        cmd = 16'hA2E2;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort_rd_a_sel", 32'(readnum), 32'd2);
        @(negedge clk);
        check("abort_rd_b_sel", 32'(readnum), 32'd2);
        #1 reset_n = 1'b0;
        #1;
        check("abort_ready_now", 32'(cmd_ready), 32'd1);
        check("abort_write_now", 32'(write), 32'd0);
        wr_seen = 0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (write) wr_seen++;
            if (done) done_seen++;
        end
        check("abort_no_write", 32'(wr_seen), 32'd0);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_readnum", 32'(readnum), 32'd0);
        check("abort_writenum", 32'(writenum), 32'd0);
        check("abort_data_in", 32'(data_in), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_rf_r7", 32'(rf[7]), 32'h00000084);
        $display("txn abort      add_r7 aborted, writes=%0d done=%0d r7=%h", wr_seen, done_seen, rf[7]);
        exec(16'hE700, "rdr_r7", 2, 0, 3'd0, 16'h0000);
        check("rdr_r7_result", 32'(last_result), 32'h00000084);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
